i2s_rx_drain_ctrl: RTL and testbench

//  Read-side sequencer for the I2S receive FIFO, in the rclk domain.
//  - Drains 32-bit words from the FIFO and assembles them into left/right sample pairs.
//  - Formats each sample for 16- or 32-bit frames.
//  - Presents each pair on a valid/ready stream towards the host/bus side.
//  - Tracks FIFO overrun and raises a threshold interrupt after N delivered pairs.

---
 rtl/i2s_rx_drain_ctrl.sv | 143 ++++++++++++++
 tb/tb_i2s_rx_drain_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_drain_ctrl.sv
// Read-side sequencer for the I2S receive FIFO (rclk domain).
// Latency: en in IDLE -> fifo_ren next cycle -> capture -> m_valid 3 cycles after en.
// Backpressure: m_left/m_right held stable and no FIFO reads while m_valid && !m_ready.
//
// Ports:
//   rclk, rst                       clock, synchronous active-high reset
//   en, stereo, frame_size, sign_ext drain enable and per-pair configuration
//   fifo_empty, fifo_full, fifo_ren, fifo_dout   FIFO read interface (1-cycle read latency)
//   m_valid, m_ready, m_left, m_right             sample-pair output stream
//   irq_thresh, irq, frame_cnt                    pair counting and threshold interrupt
//   overrun, clr_overrun                          sticky FIFO-full indicator
module i2s_rx_drain_ctrl #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             en,
  input  logic             stereo,
  input  logic             frame_size,
  input  logic             sign_ext,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_ren,
  input  logic [DW-1:0]    fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_left,
  output logic [DW-1:0]    m_right,
  input  logic [CNT_W-1:0] irq_thresh,
  output logic             irq,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, PRESENT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             slot;
  logic             sh_stereo, sh_frame_size, sh_sign_ext;
  logic [CNT_W-1:0] pair_cnt;
  logic [DW-1:0]    sample;
  logic             handshake;
  logic             relatch;

  assign m_valid   = (state == PRESENT);
  assign handshake = m_valid && m_ready;
  // Config is only sampled at a pair boundary: leaving IDLE or finishing a pair with en held.
  assign relatch   = ((state == IDLE) && en) || (handshake && en);

  // 16-bit samples live in word[15:0]; the upper bits are filled with the
  // sign bit only when sign extension is enabled.
  always_comb begin
    sample = fifo_dout;
    if (!sh_frame_size) begin
      sample = {{(DW-16){fifo_dout[15] & sh_sign_ext}}, fifo_dout[15:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_ren  = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!fifo_empty) begin
          fifo_ren  = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = (sh_stereo && !slot) ? ISSUE : PRESENT;
      end
      PRESENT: begin
        if (m_ready) state_nxt = en ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must suppress a read even though the state register has not yet cleared.
    if (rst) fifo_ren = 1'b0;
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state         <= IDLE;
      slot          <= 1'b0;
      sh_stereo     <= 1'b0;
      sh_frame_size <= 1'b0;
      sh_sign_ext   <= 1'b0;
      m_left        <= '0;
      m_right       <= '0;
      irq           <= 1'b0;
      frame_cnt     <= '0;
      pair_cnt      <= '0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;
      irq   <= 1'b0;

      if (relatch) begin
        sh_stereo     <= stereo;
        sh_frame_size <= frame_size;
        sh_sign_ext   <= sign_ext;
        slot          <= 1'b0;
      end

      if (state == CAPTURE) begin
        if (sh_stereo && !slot) begin
          m_left <= sample;
          slot   <= 1'b1;
        end else begin
          m_right <= sample;
          if (!sh_stereo) m_left <= sample;
        end
      end

      if (handshake) begin
        frame_cnt <= frame_cnt + CNT_ONE;
        if (irq_thresh == '0) begin
          pair_cnt <= '0;
        end else if ((pair_cnt + CNT_ONE) == irq_thresh) begin
          irq      <= 1'b1;
          pair_cnt <= '0;
        end else begin
          pair_cnt <= pair_cnt + CNT_ONE;
        end
      end

      // A new full condition takes priority over a software clear in the same cycle.
      if (fifo_full && en) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_drain_ctrl.sv
module tb_i2s_rx_drain_ctrl;

  logic        rclk = 1'b0;
  logic        rst, en, stereo, frame_size, sign_ext;
  logic        fifo_full, fifo_ren, m_valid, m_ready, irq, overrun, clr_overrun;
  logic        fifo_empty;
  logic [31:0] fifo_dout, m_left, m_right;
  logic [15:0] irq_thresh, frame_cnt;

  i2s_rx_drain_ctrl #(.DW(32), .CNT_W(16)) dut (
    .rclk(rclk), .rst(rst), .en(en), .stereo(stereo), .frame_size(frame_size),
    .sign_ext(sign_ext), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ren(fifo_ren), .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_left(m_left), .m_right(m_right), .irq_thresh(irq_thresh), .irq(irq),
    .frame_cnt(frame_cnt), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 rclk = ~rclk;

  // Behavioural FIFO: circular store, registered read data.
  logic [31:0] mem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);
  always @(posedge rclk) begin
    if (fifo_ren) begin
      fifo_dout <= mem[rd_cnt % 256];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_frame = '0;
  int          exp_pc    = 0;
  int          irq_seen  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_cnt % 256] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic fs, input logic se);
    logic [31:0] r;
    if (fs) r = w;
    else if (se && w[15]) r = 32'hFFFF0000 | (w & 32'h0000FFFF);
    else r = w & 32'h0000FFFF;
    return r;
  endfunction

  task automatic wait_valid(input string tag);
    int n = 0;
    while (m_valid !== 1'b1 && n < 200) begin
      @(negedge rclk);
      n++;
    end
    check(tag, {31'b0, m_valid}, 32'd1);
  endtask

  // Called at a negedge with m_valid high; stalls, checks data, completes the handshake.
  task automatic take(input logic [31:0] el, input logic [31:0] er, input int stall, input string tag);
    logic exp_irq;
    repeat (stall) begin
      m_ready = 1'b0;
      @(negedge rclk);
      check({tag, "_hold_valid"}, {31'b0, m_valid}, 32'd1);
      check({tag, "_hold_ren"}, {31'b0, fifo_ren}, 32'd0);
    end
    check({tag, "_left"}, m_left, el);
    check({tag, "_right"}, m_right, er);
    m_ready = 1'b1;
    @(posedge rclk);
    #1;
    m_ready = 1'b0;
    exp_frame = exp_frame + 16'd1;
    exp_irq = 1'b0;
    if (irq_thresh != 16'd0) begin
      if (exp_pc + 1 == int'(irq_thresh)) begin
        exp_irq = 1'b1;
        exp_pc  = 0;
      end else begin
        exp_pc = exp_pc + 1;
      end
    end else begin
      exp_pc = 0;
    end
    if (irq === 1'b1) irq_seen++;
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
    check({tag, "_frame_cnt"}, {16'b0, frame_cnt}, {16'b0, exp_frame});
    check({tag, "_valid_drop"}, {31'b0, m_valid}, 32'd0);
    @(negedge rclk);
  endtask

  initial begin
    logic [31:0] w [0:15];
    int np, st, hits;
    rst = 1'b1; en = 1'b0; stereo = 1'b0; frame_size = 1'b1; sign_ext = 1'b0;
    fifo_full = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0; irq_thresh = 16'd0;
    repeat (3) @(negedge rclk);
    rst = 1'b0;
    @(negedge rclk);
    check("rst_ren", {31'b0, fifo_ren}, 32'd0);
    check("rst_valid", {31'b0, m_valid}, 32'd0);
    check("rst_left", m_left, 32'd0);
    check("rst_right", m_right, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_frame", {16'b0, frame_cnt}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);

    // Mono 32-bit latency
    push(32'hDEADBEEF);
    en = 1'b1;
    @(negedge rclk);
    check("lat_c1_ren", {31'b0, fifo_ren}, 32'd1);
    check("lat_c1_valid", {31'b0, m_valid}, 32'd0);
    @(negedge rclk);
    check("lat_c2_ren", {31'b0, fifo_ren}, 32'd0);
    check("lat_c2_valid", {31'b0, m_valid}, 32'd0);
    @(negedge rclk);
    check("lat_c3_valid", {31'b0, m_valid}, 32'd1);
    en = 1'b0;
    take(32'hDEADBEEF, 32'hDEADBEEF, 0, "mono32");

    // Stereo 16-bit, sign extension on then off
    stereo = 1'b1; frame_size = 1'b0; sign_ext = 1'b1;
    push(32'h00008001); push(32'h00007FFF);
    en = 1'b1;
    wait_valid("st16se_valid");
    en = 1'b0;
    take(32'hFFFF8001, 32'h00007FFF, 0, "st16se");
    sign_ext = 1'b0;
    push(32'h00008001); push(32'h00007FFF);
    en = 1'b1;
    wait_valid("st16ze_valid");
    en = 1'b0;
    take(32'h00008001, 32'h00007FFF, 0, "st16ze");

    // Backpressure: 10 stalled cycles
    stereo = 1'b0; frame_size = 1'b1;
    push(32'hA5A55A5A);
    en = 1'b1;
    wait_valid("bp_valid");
    en = 1'b0;
    take(32'hA5A55A5A, 32'hA5A55A5A, 10, "bp");

    // Stereo underflow, en dropped while waiting for the right word
    stereo = 1'b1;
    push(32'h11112222);
    en = 1'b1;
    repeat (4) @(negedge rclk);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("uf_wait_ren", {31'b0, fifo_ren}, 32'd0);
      check("uf_wait_valid", {31'b0, m_valid}, 32'd0);
      @(negedge rclk);
    end
    push(32'h33334444);
    wait_valid("uf_valid");
    take(32'h11112222, 32'h33334444, 0, "uf");

    // Idle with data present: no reads
    stereo = 1'b0;
    for (int i = 0; i < 7; i++) push(32'h100 + i);
    repeat (3) begin
      @(negedge rclk);
      check("idle_no_ren", {31'b0, fifo_ren}, 32'd0);
    end

    // Threshold interrupt, 7 pairs with irq_thresh=3
    irq_thresh = 16'd3;
    irq_seen = 0;
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid("irq_valid");
      if (i == 6) en = 1'b0;
      take(32'h100 + i, 32'h100 + i, i % 2, "irq3");
    end
    check("irq3_pulses", irq_seen, 32'd2);
    check("irq3_frames", {16'b0, frame_cnt}, 32'd12);

    // Randomized batches against the model
    for (int b = 0; b < 8; b++) begin
      stereo = 1'($urandom_range(0, 1));
      frame_size = 1'($urandom_range(0, 1));
      sign_ext = 1'($urandom_range(0, 1));
      irq_thresh = 16'($urandom_range(0, 4));
      np = $urandom_range(1, 6);
      for (int i = 0; i < 2 * np; i++) begin
        w[i] = $urandom;
        if (stereo || (i % 2 == 0)) push(w[i]);
      end
      en = 1'b1;
      for (int p = 0; p < np; p++) begin
        wait_valid("rnd_valid");
        if (p == np - 1) en = 1'b0;
        st = $urandom_range(0, 3);
        if (stereo)
          take(fmt(w[2*p], frame_size, sign_ext), fmt(w[2*p+1], frame_size, sign_ext), st, "rnd");
        else
          take(fmt(w[2*p], frame_size, sign_ext), fmt(w[2*p], frame_size, sign_ext), st, "rnd");
      end
    end

    // Overrun: full gated by en, set beats clear, sticky, clear
    irq_thresh = 16'd0;
    stereo = 1'b0; frame_size = 1'b1;
    fifo_full = 1'b1;
    @(negedge rclk);
    check("ovr_no_en", {31'b0, overrun}, 32'd0);
    en = 1'b1; clr_overrun = 1'b1;
    @(negedge rclk);
    check("ovr_set_wins", {31'b0, overrun}, 32'd1);
    fifo_full = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(negedge rclk);
    check("ovr_sticky", {31'b0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    @(negedge rclk);
    clr_overrun = 1'b0;
    check("ovr_clear", {31'b0, overrun}, 32'd0);

    // Reset while presenting a pair
    en = 1'b0;
    push(32'hCAFEF00D);
    wait_valid("rstp_valid");
    check("rstp_left", m_left, 32'hCAFEF00D);
    rst = 1'b1;
    @(posedge rclk);
    #1;
    check("rstp_valid_low", {31'b0, m_valid}, 32'd0);
    check("rstp_frame", {16'b0, frame_cnt}, 32'd0);
    check("rstp_left_zero", m_left, 32'd0);
    check("rstp_ren", {31'b0, fifo_ren}, 32'd0);
    @(negedge rclk);
    rst = 1'b0;
    @(negedge rclk);
    check("post_rst_valid", {31'b0, m_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
